// File: rtl/snake_pkg.sv
// Shared types and limits for the Snake score path.
// BCD digit type plus the 99 ceiling used by the score counter.
package snake_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX        = 4'd9;
   localparam bcd_t SCORE_MAX_TENS = 4'd9;
   localparam bcd_t SCORE_MAX_ONES = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) counter; q is registered, carry is combinational (en && q==9).
// No backpressure: sat_hold blocks the step so the parent can decide saturate vs wrap.
module bcd_digit
   import snake_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic sat_hold,
   output bcd_t q,
   output logic carry
);

   assign carry = en && (q == BCD_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && !sat_hold) begin
         q <= (q == BCD_MAX) ? '0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score for the display stage; digits update one clk after the eat event, no backpressure.
// Optional high-score register (game_over rising edge) is built when SCORE_HIGH_SCORE_EN is defined.
module score_bcd_counter
   import snake_pkg::*;
#(
   parameter int WRAP        = 0,
   parameter int EDGE_DETECT = 1
)
(
   input  logic clk,
   input  logic reset,
   input  logic eat,
   input  logic clear,
   input  logic game_over,
   output bcd_t ones,
   output bcd_t tens,
   output logic at_max,
   output logic wrapped
`ifdef SCORE_HIGH_SCORE_EN
  ,output bcd_t hi_ones,
   output bcd_t hi_tens
`endif
);

   logic eat_q;
   logic inc;
   logic step;
   logic sat_hold;
   logic ones_carry;
   logic tens_carry;

   assign inc      = (EDGE_DETECT != 0) ? (eat & ~eat_q) : eat;
   // clear and game_over both swallow the event before it reaches the digits
   assign step     = inc & ~clear & ~game_over;
   assign at_max   = (tens == SCORE_MAX_TENS) && (ones == SCORE_MAX_ONES);
   assign sat_hold = (WRAP == 0) && at_max;

   bcd_digit u_ones (
      .clk      (clk),
      .reset    (reset),
      .clr      (clear),
      .en       (step),
      .sat_hold (sat_hold),
      .q        (ones),
      .carry    (ones_carry)
   );

   bcd_digit u_tens (
      .clk      (clk),
      .reset    (reset),
      .clr      (clear),
      .en       (ones_carry),
      .sat_hold (sat_hold),
      .q        (tens),
      .carry    (tens_carry)
   );

   // tens carry only fires on a 99 -> 00 step, so it marks the rollover
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eat_q   <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         eat_q   <= eat;
         wrapped <= (WRAP != 0) && tens_carry;
      end
   end

`ifdef SCORE_HIGH_SCORE_EN
   logic go_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         go_q    <= 1'b0;
         hi_ones <= '0;
         hi_tens <= '0;
      end else begin
         go_q <= game_over;
         if (game_over && !go_q && ({tens, ones} > {hi_tens, hi_ones})) begin
            hi_ones <= ones;
            hi_tens <= tens;
         end
      end
   end
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: saturating and wrapping instances driven in parallel,
// checked every cycle against an integer score model plus literal spot checks.
module tb_score_bcd_counter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic eat = 1'b0;
   logic clear = 1'b0;
   logic game_over = 1'b0;

   logic [3:0] s_ones, s_tens, w_ones, w_tens;
   logic       s_at_max, s_wrapped, w_at_max, w_wrapped;
`ifdef SCORE_HIGH_SCORE_EN
   logic [3:0] s_hi_ones, s_hi_tens, w_hi_ones, w_hi_tens;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   score_bcd_counter #(.WRAP(0), .EDGE_DETECT(1)) dut_sat (
      .clk(clk), .reset(reset), .eat(eat), .clear(clear), .game_over(game_over),
      .ones(s_ones), .tens(s_tens), .at_max(s_at_max), .wrapped(s_wrapped)
`ifdef SCORE_HIGH_SCORE_EN
     ,.hi_ones(s_hi_ones), .hi_tens(s_hi_tens)
`endif
   );

   score_bcd_counter #(.WRAP(1), .EDGE_DETECT(1)) dut_wrap (
      .clk(clk), .reset(reset), .eat(eat), .clear(clear), .game_over(game_over),
      .ones(w_ones), .tens(w_tens), .at_max(w_at_max), .wrapped(w_wrapped)
`ifdef SCORE_HIGH_SCORE_EN
     ,.hi_ones(w_hi_ones), .hi_tens(w_hi_tens)
`endif
   );

   // Model: plain integer scores, previous-input flags and a high score
   int  m_sat, m_wrap, m_hi;
   bit  m_wrapped, m_eat_prev, m_go_prev;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sat = 0; m_wrap = 0; m_hi = 0;
         m_wrapped = 0; m_eat_prev = 0; m_go_prev = 0;
      end else begin
         m_wrapped = 0;
         if (game_over && !m_go_prev && m_sat > m_hi) m_hi = m_sat;
         if (clear) begin
            m_sat = 0;
            m_wrap = 0;
         end else if (!game_over && eat && !m_eat_prev) begin
            m_sat = (m_sat == 99) ? 99 : m_sat + 1;
            if (m_wrap == 99) begin
               m_wrap = 0;
               m_wrapped = 1;
            end else begin
               m_wrap = m_wrap + 1;
            end
         end
         m_eat_prev = eat;
         m_go_prev  = game_over;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("sat_ones",    int'(s_ones),    m_sat % 10);
      chk("sat_tens",    int'(s_tens),    m_sat / 10);
      chk("sat_at_max",  int'(s_at_max),  int'(m_sat == 99));
      chk("sat_wrapped", int'(s_wrapped), 0);
      chk("wrap_ones",   int'(w_ones),    m_wrap % 10);
      chk("wrap_tens",   int'(w_tens),    m_wrap / 10);
      chk("wrap_at_max", int'(w_at_max),  int'(m_wrap == 99));
      chk("wrap_wrapped",int'(w_wrapped), int'(m_wrapped));
`ifdef SCORE_HIGH_SCORE_EN
      chk("hi_score",    int'(s_hi_tens) * 10 + int'(s_hi_ones), m_hi);
`endif
   end

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         eat = 1'b1;
         @(negedge clk);
         eat = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic end_game(input int hi_exp);
      game_over = 1'b1;
      repeat (2) @(negedge clk);
`ifdef SCORE_HIGH_SCORE_EN
      chk("hi_literal", int'(s_hi_tens) * 10 + int'(s_hi_ones), hi_exp);
`else
      chk("frozen_score", int'(s_tens) * 10 + int'(s_ones), m_sat);
      if (hi_exp < 0) $display("unexpected high score argument");
`endif
      game_over = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   int sat_seq[3]  = '{99, 99, 99};
   int wrap_seq[3] = '{99, 0, 1};

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ones", int'(s_ones), 0);
      chk("reset_tens", int'(s_tens), 0);
      reset = 1'b0;
      @(negedge clk);

      // game 1: 23, then freeze while eating, then eat held across game_over release
      edges(23);
      chk("game1_score", int'(s_tens) * 10 + int'(s_ones), 23);
      game_over = 1'b1;
      @(negedge clk);
      edges(4);
      chk("frozen_23", int'(s_tens) * 10 + int'(s_ones), 23);
      eat = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_spurious_edge", int'(s_tens) * 10 + int'(s_ones), 23);
      eat = 1'b0;
      @(negedge clk);
      edges(1);
      chk("edge_after_release", int'(s_tens) * 10 + int'(s_ones), 24);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      edges(23);
      end_game(23);
      edges(17);
      end_game(23);
      edges(23);
      end_game(23);
      edges(41);
      end_game(41);

      // held-high eat counts once per rising edge
      for (int i = 0; i < 12; i++) begin
         eat = 1'b1;
         repeat (5) @(negedge clk);
         eat = 1'b0;
         @(negedge clk);
      end
      chk("held_ones", int'(s_ones), 2);
      chk("held_tens", int'(s_tens), 1);

      // clear beats a same-cycle edge at 45
      edges(33);
      chk("score_45", int'(s_tens) * 10 + int'(s_ones), 45);
      clear = 1'b1;
      eat = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_wins", int'(s_tens) * 10 + int'(s_ones), 0);
      eat = 1'b0;
      @(negedge clk);
      edges(1);
      chk("after_clear", int'(s_tens) * 10 + int'(s_ones), 1);

      // top of range: saturate vs wrap
      edges(97);
      chk("preload_98", int'(w_tens) * 10 + int'(w_ones), 98);
      for (int i = 0; i < 3; i++) begin
         eat = 1'b1;
         @(negedge clk);
         chk("sat_top", int'(s_tens) * 10 + int'(s_ones), sat_seq[i]);
         chk("wrap_top", int'(w_tens) * 10 + int'(w_ones), wrap_seq[i]);
         chk("wrap_pulse", int'(w_wrapped), int'(i == 1));
         eat = 1'b0;
         @(negedge clk);
         chk("wrap_pulse_low", int'(w_wrapped), 0);
      end
      chk("sat_at_max_lit", int'(s_at_max), 1);

      // async reset at 37 clears before the next clock edge
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      edges(37);
      chk("score_37", int'(s_tens) * 10 + int'(s_ones), 37);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_ones", int'(s_ones), 0);
      chk("async_tens", int'(s_tens), 0);
`ifdef SCORE_HIGH_SCORE_EN
      chk("async_hi", int'(s_hi_tens) * 10 + int'(s_hi_ones), 0);
`endif
      eat = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("first_edge_after_reset", int'(s_tens) * 10 + int'(s_ones), 1);
      eat = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
